veririsc_ctrl_fsm: RTL

- 8-phase instruction-sequencing controller for the VeriRISC core.
- Owns the select of the 5-bit address multiplexor: sel=1 drives the PC onto the address bus, sel=0 drives the IR operand address.
- Also generates the memory, register-load, PC and bus-enable strobes for each instruction.
- Sits between the instruction register (opcode source), the accumulator zero flag and the datapath/memory.

---
 rtl/veririsc_pkg.sv | 34 +++
 rtl/veririsc_phase_counter.sv | 36 +++
 rtl/veririsc_ctrl_fsm.sv | 113 +++++++++++
 3 files changed

// File: rtl/veririsc_pkg.sv
// Shared constants for the VeriRISC controller: widths, opcodes, phases.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package veririsc_pkg;

  localparam int OPCODE_W = 3;
  localparam int PHASE_W  = 3;

  // Opcodes as held in the instruction register
  localparam logic [OPCODE_W-1:0] HLT = 3'd0;
  localparam logic [OPCODE_W-1:0] SKZ = 3'd1;
  localparam logic [OPCODE_W-1:0] ADD = 3'd2;
  localparam logic [OPCODE_W-1:0] AND = 3'd3;
  localparam logic [OPCODE_W-1:0] XOR = 3'd4;
  localparam logic [OPCODE_W-1:0] LDA = 3'd5;
  localparam logic [OPCODE_W-1:0] STO = 3'd6;
  localparam logic [OPCODE_W-1:0] JMP = 3'd7;

  // Instruction phases, in execution order
  localparam logic [PHASE_W-1:0] INST_ADDR  = 3'd0;
  localparam logic [PHASE_W-1:0] INST_FETCH = 3'd1;
  localparam logic [PHASE_W-1:0] INST_LOAD  = 3'd2;
  localparam logic [PHASE_W-1:0] IDLE       = 3'd3;
  localparam logic [PHASE_W-1:0] OP_ADDR    = 3'd4;
  localparam logic [PHASE_W-1:0] OP_FETCH   = 3'd5;
  localparam logic [PHASE_W-1:0] ALU_OP     = 3'd6;
  localparam logic [PHASE_W-1:0] STORE      = 3'd7;

  // Instructions that read an operand from memory into the accumulator path
  function automatic logic is_aluop(input logic [OPCODE_W-1:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/veririsc_phase_counter.sv
// Wrapping phase counter for the VeriRISC sequencer.
// Latency: advances one phase per enabled clock edge.
// Backpressure: holds when en_i=0 or freeze_i=1.
module veririsc_phase_counter
  import veririsc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               freeze_i,
  output logic [PHASE_W-1:0] phase_o
);

  logic [PHASE_W-1:0] cnt_q;
  logic [PHASE_W-1:0] cnt_d;

  // Next phase: step when enabled and not frozen; natural wrap STORE -> INST_ADDR
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && !freeze_i) begin
      cnt_d = cnt_q + PHASE_W'(1);
    end
  end

  // Phase register, cleared asynchronously to INST_ADDR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= INST_ADDR;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_o = cnt_q;

endmodule

// File: rtl/veririsc_ctrl_fsm.sv
// VeriRISC 8-phase controller: address-mux select and datapath/memory strobes.
// Latency: outputs decode combinationally from the registered phase (0 cycles).
// Backpressure: en=0 holds phase and outputs; a halt freezes the phase until rst.
module veririsc_ctrl_fsm
  import veririsc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output logic                sel,
  output logic                rd,
  output logic                ld_ir,
  output logic                halt,
  output logic                inc_pc,
  output logic                ld_ac,
  output logic                ld_pc,
  output logic                wr,
  output logic                data_e,
  output logic [PHASE_W-1:0]  phase
);

  logic [PHASE_W-1:0] phase_q;
  logic               halted_q;
  logic               halted_d;
  logic               aluop;

  // Once halted the counter freezes at OP_FETCH, the phase after OP_ADDR
  veririsc_phase_counter u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .en_i     (en),
    .freeze_i (halted_q),
    .phase_o  (phase_q)
  );

  // Halt is sticky: set on the enabled edge leaving OP_ADDR with HLT
  always_comb begin
    halted_d = halted_q;
    if (en && (phase_q == OP_ADDR) && (opcode == HLT)) begin
      halted_d = 1'b1;
    end
  end

  // Halted flag register; only rst clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign aluop = is_aluop(opcode);

  // Strobe decode; phases 0-3 never look at opcode so an unsettled IR is harmless
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    halt   = 1'b0;
    inc_pc = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (phase_q)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == HLT);
        end
        OP_FETCH: begin
          rd = aluop;
        end
        ALU_OP: begin
          rd     = aluop;
          inc_pc = (opcode == SKZ) && zero;
          ld_pc  = (opcode == JMP);
          data_e = (opcode == STO);
        end
        STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = (opcode == JMP);
          wr     = (opcode == STO);
          data_e = (opcode == STO);
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

  assign phase = phase_q;

endmodule
